// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// State encodings, byte width and default geometry of the instruction memory.
package loader_pkg;

   localparam int BYTE_W        = 8;
   localparam int DEF_ADDR_STEP = 8;
   localparam int DEF_MAX_WORDS = 32;

   typedef logic [2:0] loaderState_t;

   localparam loaderState_t IDLE = 3'd0;
   localparam loaderState_t HI   = 3'd1;
   localparam loaderState_t LO   = 3'd2;
   localparam loaderState_t CHK  = 3'd3;
   localparam loaderState_t DONE = 3'd4;
   localparam loaderState_t ERR  = 3'd5;

endpackage

// File: rtl/byte_packer.sv
// Packs a high/low byte pair into one instruction word.
// The high byte is held until the low byte arrives; the finished word and a
// one-cycle wordValid pulse appear on the cycle after the low byte strobe.
module byte_packer
   import loader_pkg::*;
#(
   parameter int INSTR_W = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [BYTE_W-1:0]  byteIn,
   input  logic               hiStrobe,
   input  logic               loStrobe,
   output logic [INSTR_W-1:0] word,
   output logic               wordValid
);

   logic [BYTE_W-1:0] hiReg;

   // Hold the high byte, then register the assembled word with a single-cycle valid.
   always_ff @(posedge clk) begin
      if (!rst) begin
         hiReg     <= '0;
         word      <= '0;
         wordValid <= 1'b0;
      end else begin
         wordValid <= loStrobe;
         if (hiStrobe) begin
            hiReg <= byteIn;
         end
         if (loStrobe) begin
            word <= INSTR_W'({hiReg, byteIn});
         end
      end
   end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader in front of the processor's instruction memory.
// Stream: header N, then N high/low byte pairs; with LOADER_CHECKSUM_EN
// defined a trailing checksum byte (XOR of header and data) is also checked.
// The processor is held in reset (cpu_rst low) until the image is loaded.
module program_loader
   import loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int INSTR_W   = 16,
   parameter int ADDR_STEP = DEF_ADDR_STEP,
   parameter int BASE_ADDR = 0,
   parameter int MAX_WORDS = DEF_MAX_WORDS
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         in_data,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               reload,
   output logic               imem_we,
   output logic [ADDR_W-1:0]  imem_addr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_rst,
   output logic               done,
   output logic               error,
   output logic [5:0]         word_count
);

   loaderState_t      stateReg;
   logic [5:0]        numWordsReg;
   logic [5:0]        wordCountReg;
   logic [ADDR_W-1:0] addrReg;
   logic              cpuRstReg;
   logic              accept;
   logic              lastWord;
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]        chkReg;
`endif

   // A byte moves only when both sides agree; no back-pressure while loading.
   always_comb begin
      in_ready = (stateReg != DONE) && (stateReg != ERR);
      accept   = in_valid && in_ready;
      lastWord = (wordCountReg + 6'd1) == numWordsReg;
   end

   byte_packer #(
      .INSTR_W (INSTR_W)
   ) uPacker (
      .clk       (clk),
      .rst       (rst),
      .byteIn    (in_data),
      .hiStrobe  (accept && (stateReg == HI)),
      .loStrobe  (accept && (stateReg == LO)),
      .word      (imem_wdata),
      .wordValid (imem_we)
   );

   // Loader FSM, word counter, write address and processor-release register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stateReg     <= IDLE;
         numWordsReg  <= '0;
         wordCountReg <= '0;
         addrReg      <= ADDR_W'(BASE_ADDR);
         cpuRstReg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
         chkReg       <= '0;
`endif
      end else begin
         // Address moves on once the current write has been presented.
         if (imem_we) begin
            addrReg <= addrReg + ADDR_W'(ADDR_STEP);
         end
         // Release the processor one cycle after DONE is entered.
         cpuRstReg <= (stateReg == DONE);

         case (stateReg)
            IDLE: begin
               if (accept) begin
                  if ((in_data == 8'd0) || (in_data > 8'(MAX_WORDS))) begin
                     stateReg <= ERR;
                  end else begin
                     numWordsReg <= in_data[5:0];
                     stateReg    <= HI;
                  end
`ifdef LOADER_CHECKSUM_EN
                  chkReg <= in_data;
`endif
               end
            end
            HI: begin
               if (accept) begin
                  stateReg <= LO;
`ifdef LOADER_CHECKSUM_EN
                  chkReg <= chkReg ^ in_data;
`endif
               end
            end
            LO: begin
               if (accept) begin
                  wordCountReg <= wordCountReg + 6'd1;
`ifdef LOADER_CHECKSUM_EN
                  chkReg   <= chkReg ^ in_data;
                  stateReg <= lastWord ? CHK : HI;
`else
                  stateReg <= lastWord ? DONE : HI;
`endif
               end
            end
`ifdef LOADER_CHECKSUM_EN
            CHK: begin
               if (accept) begin
                  stateReg <= (in_data == chkReg) ? DONE : ERR;
               end
            end
`endif
            DONE, ERR: begin
               if (reload) begin
                  stateReg     <= IDLE;
                  wordCountReg <= '0;
                  addrReg      <= ADDR_W'(BASE_ADDR);
                  cpuRstReg    <= 1'b0;
               end
            end
            default: begin
               stateReg <= IDLE;
            end
         endcase
      end
   end

   // Status outputs derived from state and registers.
   always_comb begin
      imem_addr  = addrReg;
      cpu_rst    = cpuRstReg;
      done       = (stateReg == DONE);
      error      = (stateReg == ERR);
      word_count = wordCountReg;
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed testbench for program_loader (default build or LOADER_CHECKSUM_EN).
module tb_program_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic        reload;
   logic        imem_we;
   logic [7:0]  imem_addr;
   logic [15:0] imem_wdata;
   logic        cpu_rst;
   logic        done;
   logic        error;
   logic [5:0]  word_count;

   int passCount  = 0;
   int totalCount = 0;

   logic [7:0]  stream[$];
   logic [7:0]  wrAddr[$];
   logic [15:0] wrData[$];

   program_loader dut (
      .clk        (clk),
      .rst        (rst),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .reload     (reload),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_rst    (cpu_rst),
      .done       (done),
      .error      (error),
      .word_count (word_count)
   );

   always #5 clk = ~clk;

   // Capture every instruction-memory write, one line per write.
   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wrAddr.push_back(imem_addr);
         wrData.push_back(imem_wdata);
         $display("write addr=%02h data=%04h", imem_addr, imem_wdata);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      totalCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic sendByte(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic gapCycle();
      in_valid = 1'b0;
      in_data  = 8'hEE;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic pulseReload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   // Send the queued stream; the checksum byte is appended when enabled.
   task automatic sendStream(input bit toggle);
      logic [7:0] x;
      x = 8'h00;
      foreach (stream[i]) begin
         if (toggle && i > 0) gapCycle();
         sendByte(stream[i]);
         x = x ^ stream[i];
      end
`ifdef LOADER_CHECKSUM_EN
      if (toggle) gapCycle();
      sendByte(x);
`endif
      stream.delete();
   endtask

   initial begin
      int base;
      rst      = 1'b0;
      reload   = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;

      // Reset state
      idleCycle();
      idleCycle();
      check("rst_in_ready", in_ready, 1);
      check("rst_imem_we", imem_we, 0);
      check("rst_imem_addr", imem_addr, 8'h00);
      check("rst_imem_wdata", imem_wdata, 16'h0000);
      check("rst_cpu_rst", cpu_rst, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_word_count", word_count, 0);
      rst = 1'b1;
      idleCycle();

      // Test 1: two words back to back
      base = wrAddr.size();
      stream = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
      sendStream(1'b0);
      check("t1_done_t1", done, 1);
      check("t1_cpu_rst_t1", cpu_rst, 0);
      check("t1_in_ready_done", in_ready, 0);
      idleCycle();
      check("t1_cpu_rst_t2", cpu_rst, 1);
      check("t1_word_count", word_count, 2);
      check("t1_nwrites", wrAddr.size() - base, 2);
      check("t1_w0_addr", wrAddr[base], 8'h00);
      check("t1_w0_data", wrData[base], 16'h1234);
      check("t1_w1_addr", wrAddr[base+1], 8'h08);
      check("t1_w1_data", wrData[base+1], 16'hABCD);
      pulseReload();
      check("t1_reload_done", done, 0);
      check("t1_reload_cpu_rst", cpu_rst, 0);
      check("t1_reload_wc", word_count, 0);
      check("t1_reload_addr", imem_addr, 8'h00);

      // Test 2a: header 00
      base = wrAddr.size();
      sendByte(8'h00);
      idleCycle();
      check("t2a_error", error, 1);
      check("t2a_in_ready", in_ready, 0);
      check("t2a_cpu_rst", cpu_rst, 0);
      check("t2a_nwrites", wrAddr.size() - base, 0);
      pulseReload();
      check("t2a_reload_error", error, 0);
      check("t2a_reload_ready", in_ready, 1);

      // Test 2b: header 0x21 exceeds the word limit
      sendByte(8'h21);
      idleCycle();
      check("t2b_error", error, 1);
      check("t2b_in_ready", in_ready, 0);
      check("t2b_cpu_rst", cpu_rst, 0);
      check("t2b_nwrites", wrAddr.size() - base, 0);
      pulseReload();
      check("t2b_reload_error", error, 0);

      // Test 3: valid toggling every cycle
      base = wrAddr.size();
      stream = '{8'h01, 8'h5A, 8'hA5};
      sendStream(1'b1);
      check("t3_done", done, 1);
      idleCycle();
      idleCycle();
      check("t3_nwrites", wrAddr.size() - base, 1);
      check("t3_addr", wrAddr[base], 8'h00);
      check("t3_data", wrData[base], 16'h5AA5);
      check("t3_word_count", word_count, 1);
      pulseReload();

      // Test 4: reset before the low byte
      base = wrAddr.size();
      sendByte(8'h01);
      sendByte(8'h5A);
      rst = 1'b0;
      idleCycle();
      rst = 1'b1;
      check("t4_in_ready", in_ready, 1);
      check("t4_imem_we", imem_we, 0);
      check("t4_imem_addr", imem_addr, 8'h00);
      check("t4_imem_wdata", imem_wdata, 16'h0000);
      check("t4_cpu_rst", cpu_rst, 0);
      check("t4_done", done, 0);
      check("t4_error", error, 0);
      check("t4_word_count", word_count, 0);
      idleCycle();
      check("t4_nwrites_none", wrAddr.size() - base, 0);
      stream = '{8'h01, 8'h00, 8'h01};
      sendStream(1'b0);
      idleCycle();
      check("t4_nwrites", wrAddr.size() - base, 1);
      check("t4_addr", wrAddr[base], 8'h00);
      check("t4_data", wrData[base], 16'h0001);
      check("t4_cpu_rst_rel", cpu_rst, 1);
      pulseReload();

`ifdef LOADER_CHECKSUM_EN
      // Test 5: checksum match then mismatch
      sendByte(8'h01);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h27);
      check("t5_match_done", done, 1);
      idleCycle();
      check("t5_match_cpu_rst", cpu_rst, 1);
      pulseReload();
      base = wrAddr.size();
      sendByte(8'h01);
      sendByte(8'h12);
      sendByte(8'h34);
      sendByte(8'h00);
      check("t5_bad_error", error, 1);
      idleCycle();
      check("t5_bad_cpu_rst", cpu_rst, 0);
      check("t5_bad_done", done, 0);
      check("t5_bad_nwrites", wrAddr.size() - base, 1);
      check("t5_bad_addr", wrAddr[base], 8'h00);
      check("t5_bad_data", wrData[base], 16'h1234);
      pulseReload();
`endif

      // Test 6: maximum load, then reload restarts at the base address
      base = wrAddr.size();
      stream.push_back(8'h20);
      for (int k = 0; k < 32; k++) begin
         stream.push_back(8'(k));
         stream.push_back(~8'(k));
      end
      sendStream(1'b0);
      check("t6_done", done, 1);
      idleCycle();
      check("t6_nwrites", wrAddr.size() - base, 32);
      check("t6_word_count", word_count, 32);
      check("t6_first_addr", wrAddr[base], 8'h00);
      check("t6_first_data", wrData[base], 16'h00FF);
      check("t6_last_addr", wrAddr[base+31], 8'hF8);
      check("t6_last_data", wrData[base+31], 16'h1FE0);
      pulseReload();
      base = wrAddr.size();
      stream = '{8'h01, 8'hFF, 8'hFF};
      sendStream(1'b0);
      idleCycle();
      check("t6_reload_nwrites", wrAddr.size() - base, 1);
      check("t6_reload_addr", wrAddr[base], 8'h00);
      check("t6_reload_data", wrData[base], 16'hFFFF);
      check("t6_reload_wc", word_count, 1);

      $display("%0d/%0d checks passed", passCount, totalCount);
      $finish;
   end

endmodule
